// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Optional inter-frame gap state is enabled by defining UART_ARB_GAP_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 2,
    localparam int PTR_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          tx_start_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    input  logic                          tx_done_i,
    output logic                          busy_o,
    output logic [PTR_W-1:0]              grant_id_o,
    output logic                          err_timeout_o,
    output logic [15:0]                   frame_cnt_o,
    output logic [1:0]                    dbg_state_o
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
            $error("NUM_REQ must be in 2..16");
        end
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 2");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("GAP_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
`ifdef UART_ARB_GAP_EN
        , S_GAP     = 2'd3
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        last_ptr_q, last_ptr_d;
    logic [PTR_W-1:0]        grant_id_q, grant_id_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    err_timeout_q, err_timeout_d;
    logic                    tx_start_q, busy_q;
`ifdef UART_ARB_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0]        gap_q, gap_d;
`endif

    // Rotating priority search starting just after the previous winner.
    logic             found;
    logic [PTR_W-1:0] win;
    int               idx;
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        last_ptr_d    = last_ptr_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        wd_d          = wd_q;
        frame_cnt_d   = frame_cnt_q;
        err_timeout_d = 1'b0;
        req_ready_o   = '0;
`ifdef UART_ARB_GAP_EN
        gap_d         = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready_o[win] = 1'b1;
                    tx_data_d        = req_data_i[win*DATA_WIDTH +: DATA_WIDTH];
                    grant_id_d       = win;
                    last_ptr_d       = win;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                wd_d = wd_q + 1'b1;
                // A done pulse on the final watchdog cycle still counts as success.
                if (tx_done_i) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef UART_ARB_GAP_EN
                    gap_d   = '0;
                    state_d = S_GAP;
`else
                    state_d = S_IDLE;
`endif
                end else if (wd_q == WD_LIMIT) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
`ifdef UART_ARB_GAP_EN
            S_GAP: begin
                if (gap_q == GAP_LIMIT) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            last_ptr_q    <= PTR_W'(NUM_REQ - 1);
            grant_id_q    <= '0;
            tx_data_q     <= '0;
            wd_q          <= '0;
            frame_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_ARB_GAP_EN
            gap_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            last_ptr_q    <= last_ptr_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            wd_q          <= wd_d;
            frame_cnt_q   <= frame_cnt_d;
            err_timeout_q <= err_timeout_d;
            tx_start_q    <= (state_d == S_ISSUE);
            busy_q        <= (state_d != S_IDLE);
`ifdef UART_ARB_GAP_EN
            gap_q         <= gap_d;
`endif
        end
    end

    assign tx_start_o    = tx_start_q;
    assign tx_data_o     = tx_data_q;
    assign busy_o        = busy_q;
    assign grant_id_o    = grant_id_q;
    assign err_timeout_o = err_timeout_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: round-robin order, handshake timing, watchdog,
// optional gap (UART_ARB_GAP_EN), reset mid-frame and frame counter wrap.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int T = 32;
  localparam int G = 3;
`ifdef UART_ARB_GAP_EN
  localparam int GAP_EFF = G;
`else
  localparam int GAP_EFF = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic           tx_done;
  logic           busy;
  logic [1:0]     grant_id;
  logic           err_timeout;
  logic [15:0]    frame_cnt;
  logic [1:0]     dbg_state;

  int checks = 0;
  int failures = 0;
  int m_last;
  logic [15:0] m_frames;
  logic [W-1:0] exp_q[$];

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(T), .GAP_CYCLES(G)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .tx_start_o(tx_start), .tx_data_o(tx_data),
    .tx_done_i(tx_done), .busy_o(busy), .grant_id_o(grant_id),
    .err_timeout_o(err_timeout), .frame_cnt_o(frame_cnt), .dbg_state_o(dbg_state)
  );

  // clock / time bound
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "time bound expired");
  end

  // reference: first valid requester after the previous winner, wrapping
  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // dly: cycles from tx_start to tx_done (1..T); 0 means tx_done never comes
  task automatic run_frame(input logic [N-1:0] mask, input logic [N*W-1:0] data, input int dly);
    int w;
    int lim;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] exp_b;
    w = rr_pick(m_last, mask);
    exp_rdy = '0;
    exp_rdy[w] = 1'b1;
    exp_q.push_back(data[w*W +: W]);
    req_valid = mask;
    req_data = data;
    #1;
    checks++;
    if (req_ready !== exp_rdy) begin
      failures++;
      $display("FAIL grant_ready: got=%b exp=%b", req_ready, exp_rdy);
    end
    @(negedge clk);
    m_last = w;
    req_valid = '0;
    exp_b = exp_q.pop_front();
    checks++;
    if (tx_start !== 1'b1 || tx_data !== exp_b || busy !== 1'b1) begin
      failures++;
      $display("FAIL issue: got start=%b data=%h busy=%b exp start=1 data=%h busy=1",
               tx_start, tx_data, busy, exp_b);
    end
    checks++;
    if (grant_id !== 2'(w)) begin
      failures++;
      $display("FAIL grant_id: got=%0d exp=%0d", grant_id, w);
    end
    lim = (dly == 0) ? T : dly;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      #1;
      checks++;
      if (req_ready !== '0 || tx_start !== 1'b0 || busy !== 1'b1 ||
          err_timeout !== 1'b0 || tx_data !== exp_b) begin
        failures++;
        $display("FAIL wait_done: cyc=%0d got rdy=%b start=%b busy=%b err=%b data=%h exp rdy=0 start=0 busy=1 err=0 data=%h",
                 i, req_ready, tx_start, busy, err_timeout, tx_data, exp_b);
      end
      if (i == dly) tx_done = 1'b1;
    end
    @(negedge clk);
    tx_done = 1'b0;
    req_valid = '0;
    if (dly == 0) begin
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0 || frame_cnt !== m_frames) begin
        failures++;
        $display("FAIL timeout_fire: got err=%b busy=%b cnt=%h exp err=1 busy=0 cnt=%h",
                 err_timeout, busy, frame_cnt, m_frames);
      end
      @(negedge clk);
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL timeout_once: got err=%b busy=%b exp err=0 busy=0", err_timeout, busy);
      end
    end else begin
      m_frames = m_frames + 16'd1;
      checks++;
      if (frame_cnt !== m_frames || err_timeout !== 1'b0) begin
        failures++;
        $display("FAIL frame_done: got cnt=%h err=%b exp cnt=%h err=0", frame_cnt, err_timeout, m_frames);
      end
      for (int g = 0; g < GAP_EFF; g++) begin
        req_valid = '1;
        #1;
        checks++;
        if (busy !== 1'b1 || req_ready !== '0) begin
          failures++;
          $display("FAIL gap: cyc=%0d got busy=%b rdy=%b exp busy=1 rdy=0", g, busy, req_ready);
        end
        @(negedge clk);
      end
      req_valid = '0;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL back_to_idle: got busy=%b exp=0", busy);
      end
    end
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom_range(0, 255));
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    tx_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0 || req_ready !== '0 ||
        tx_data !== '0 || grant_id !== '0 || frame_cnt !== 16'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset: got start=%b busy=%b err=%b rdy=%b data=%h gid=%0d cnt=%h st=%0d exp all 0",
               tx_start, busy, err_timeout, req_ready, tx_data, grant_id, frame_cnt, dbg_state);
    end
    rst = 1'b0;
    m_last = N - 1;
    m_frames = 16'h0;
    exp_q.delete();
  endtask

  task automatic test_all_valid();
    for (int f = 0; f < 4; f++) run_frame(4'hF, 32'hA3A2A1A0, 20);
    checks++;
    if (frame_cnt !== 16'd4) begin
      failures++;
      $display("FAIL all_valid_cnt: got=%0d exp=4", frame_cnt);
    end
  endtask

  task automatic test_single();
    run_frame(4'b0100, 32'h005A0000, 8);
    checks++;
    if (tx_data !== 8'h5A || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL single: got data=%h gid=%0d exp data=5a gid=2", tx_data, grant_id);
    end
  endtask

  task automatic test_gap();
    run_frame(4'b0011, rand_data(), 3);
    run_frame(4'b0011, rand_data(), 3);
  endtask

  task automatic test_timeout();
    run_frame(4'hF, rand_data(), 0);
    run_frame(4'hF, rand_data(), 4);
  endtask

  task automatic test_coincide();
    run_frame(N'($urandom_range(1, (1 << N) - 1)), rand_data(), T);
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++)
      run_frame(N'($urandom_range(1, (1 << N) - 1)), rand_data(), $urandom_range(0, T));
  endtask

  task automatic test_wrap();
    force dut.frame_cnt_d = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_d;
    m_frames = 16'hFFFF;
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preset: got=%h exp=ffff", frame_cnt);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_cnt !== 16'hFFFF || busy !== 1'b0) begin
      failures++;
      $display("FAIL spurious_done: got cnt=%h busy=%b exp cnt=ffff busy=0", frame_cnt, busy);
    end
    run_frame(N'($urandom_range(1, (1 << N) - 1)), rand_data(), 5);
    checks++;
    if (frame_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL wrap: got=%h exp=0000", frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100;
    req_data = rand_data();
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (dbg_state !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_wait: got st=%0d busy=%b exp st=2 busy=1", dbg_state, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0 || req_ready !== '0 ||
        tx_data !== '0 || grant_id !== '0 || frame_cnt !== 16'h0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid: got start=%b busy=%b err=%b rdy=%b data=%h gid=%0d cnt=%h st=%0d exp all 0",
               tx_start, busy, err_timeout, req_ready, tx_data, grant_id, frame_cnt, dbg_state);
    end
    m_last = N - 1;
    m_frames = 16'h0;
    exp_q.delete();
    run_frame(4'b1010, rand_data(), 6);
    checks++;
    if (grant_id !== 2'd1) begin
      failures++;
      $display("FAIL reset_mid_grant: got=%0d exp=1", grant_id);
    end
  endtask

  initial begin
    test_reset();
    test_all_valid();
    test_single();
    test_gap();
    test_timeout();
    test_coincide();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
